gcd_arbiter: RTL and testbench



---
 rtl/gcd_arbiter.sv | 157 +++++++++++++++
 tb/tb_gcd_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end that shares one gcd engine among NREQ
// requesters. Takes one operand pair at a time, answers zero-operand pairs
// locally, otherwise loads the engine and waits for its done level (with a
// watchdog), then returns the result as a one-hot, single-cycle response.
module gcd_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_u,
    input  logic [NREQ*W-1:0]   req_v,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [W-1:0]        rsp_res,
    output logic                rsp_err,
    output logic                gcd_ld,
    output logic [W-1:0]        gcd_u,
    output logic [W-1:0]        gcd_v,
    input  logic [W-1:0]        gcd_res,
    input  logic                gcd_done
);

    localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW = $clog2(TIMEOUT);
    localparam int unsigned NR = NREQ;

    // Last counter value before the watchdog fires, and the first value at
    // which the engine's done level is trusted (earlier cycles may still see
    // the previous job's done, which the engine drops two cycles after ld).
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [IW-1:0]  ptr;
    logic [IW-1:0]  grant;
    logic [IW-1:0]  pick;
    logic [IW-1:0]  idx;
    logic           any_req;
    logic [W-1:0]   pick_u;
    logic [W-1:0]   pick_v;
    logic           pick_zero;
    logic [W-1:0]   local_res;
    logic [CW-1:0]  cnt;
    logic           done_ok;
    logic           timed_out;

    // Round-robin pick: first pending requester searching upward from ptr+1.
    always_comb begin
        pick    = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = IW'((32'(ptr) + k) % NR);
            if (!any_req && req_valid[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    // Operands of the picked requester and the locally resolved zero-operand result.
    always_comb begin
        pick_u    = req_u[pick*W +: W];
        pick_v    = req_v[pick*W +: W];
        pick_zero = (pick_u == '0) || (pick_v == '0);
        local_res = (pick_u == '0) ? pick_v : pick_u;
        done_ok   = gcd_done && (cnt >= CNT_BLANK);
        timed_out = (cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a done seen on the timeout cycle takes priority.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_req) state_nx = pick_zero ? S_RESP : S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (done_ok || timed_out) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered outputs, operand latches, wait counter and grant pointer.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_res   <= '0;
            rsp_err   <= 1'b0;
            gcd_ld    <= 1'b0;
            gcd_u     <= '0;
            gcd_v     <= '0;
            cnt       <= '0;
            grant     <= '0;
            ptr       <= IW'(NREQ - 1);
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            gcd_ld    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        req_ready[pick] <= 1'b1;
                        grant           <= pick;
                        gcd_u           <= pick_u;
                        gcd_v           <= pick_v;
                        if (pick_zero) begin
                            rsp_res <= local_res;
                            rsp_err <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    gcd_ld <= 1'b1;
                    cnt    <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (done_ok) begin
                        rsp_res <= gcd_res;
                        rsp_err <= 1'b0;
                    end else if (timed_out) begin
                        rsp_res <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid[grant] <= 1'b1;
                    ptr              <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: scoreboard bench for gcd_arbiter with a behavioural gcd
// engine, directed scenarios and randomized requester traffic.
module tb_gcd_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 20;

    logic                clk = 1'b0;
    logic                resetb = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*W-1:0]   req_u = '0;
    logic [NREQ*W-1:0]   req_v = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [W-1:0]        rsp_res;
    logic                rsp_err;
    logic                gcd_ld;
    logic [W-1:0]        gcd_u;
    logic [W-1:0]        gcd_v;
    logic [W-1:0]        gcd_res = '0;
    logic                gcd_done = 1'b0;

    gcd_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .resetb    (resetb),
        .req_valid (req_valid),
        .req_u     (req_u),
        .req_v     (req_v),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err),
        .gcd_ld    (gcd_ld),
        .gcd_u     (gcd_u),
        .gcd_v     (gcd_v),
        .gcd_res   (gcd_res),
        .gcd_done  (gcd_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [W-1:0] u;
        logic [W-1:0] v;
        logic [W-1:0] res;
        logic        err;
        bit          zero;
        int unsigned acc;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    // ---------------- engine model ----------------
    bit           eng_dead = 1'b0;
    int unsigned  lat_force = 0;
    int unsigned  eng_lat = 3;
    int unsigned  age = 0;
    bit           busy = 1'b0;
    logic [W-1:0] pend = '0;

    always @(negedge clk) begin
        if (gcd_ld) begin
            age     = 0;
            busy    = 1'b1;
            pend    = ref_gcd(gcd_u, gcd_v);
            eng_lat = (lat_force != 0) ? lat_force : $urandom_range(3, 6);
            if (eng_dead) gcd_done = 1'b0;
        end else if (busy) begin
            age++;
            if (age == 2) gcd_done = 1'b0;
            if (age >= eng_lat && !eng_dead) begin
                gcd_done = 1'b1;
                gcd_res  = pend;
                busy     = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    int          last_grant = NREQ - 1;
    int unsigned ld_cyc = 0;
    bit          ld_seen = 1'b0;
    bit          prev_ld = 1'b0;
    int          rsp_count = 0;
    int          idle_cnt = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, want, $time);
        end
    endtask

    function automatic int first_set(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_expect(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        exp_t ent;
        int   e;
        if (!resetb) begin
            check("reset_outputs",
                  64'({req_ready, rsp_valid, rsp_res, rsp_err, gcd_ld, gcd_u, gcd_v}), 64'd0);
            last_grant = NREQ - 1;
            ld_seen    = 1'b0;
            idle_cnt   = 0;
        end else begin
            if (req_ready != '0 || rsp_valid != '0)
                check("ready_rsp_exclusive", 64'(req_ready & rsp_valid), 64'd0);
            if (req_ready != '0) begin
                check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                e = rr_expect(req_valid, last_grant);
                check("grant_idx", 64'(first_set(req_ready)), 64'(e));
                if (e >= 0) last_grant = e;
                idle_cnt = 0;
            end
            if (gcd_ld) begin
                check("ld_pulse", 64'(prev_ld), 64'd0);
                if (exp_q.size() == 0) begin
                    check("ld_job_pending", 64'(exp_q.size()), 64'd1);
                end else begin
                    ent = exp_q[$];
                    check("ld_nonzero_job", 64'(ent.zero), 64'd0);
                    check("ld_u", 64'(gcd_u), 64'(ent.u));
                    check("ld_v", 64'(gcd_v), 64'(ent.v));
                    check("ld_latency", 64'(cyc), 64'(ent.acc + 1));
                end
                ld_cyc  = cyc;
                ld_seen = 1'b1;
            end
            if (rsp_valid != '0) begin
                check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                if (exp_q.size() == 0) begin
                    check("rsp_has_job", 64'(exp_q.size()), 64'd1);
                end else begin
                    ent = exp_q.pop_front();
                    check("rsp_idx", 64'(first_set(rsp_valid)), 64'(ent.idx));
                    check("rsp_res", 64'(rsp_res), 64'(ent.res));
                    check("rsp_err", 64'(rsp_err), 64'(ent.err));
                    if (ent.zero)
                        check("rsp_lat_zero", 64'(cyc), 64'(ent.acc + 1));
                    else if (!ld_seen)
                        check("rsp_after_ld", 64'(ld_seen), 64'd1);
                    else
                        check("rsp_lat", 64'(cyc),
                              64'(ld_cyc + (ent.err ? TIMEOUT + 1 : eng_lat + 2)));
                end
                ld_seen = 1'b0;
                rsp_count++;
                idle_cnt = 0;
            end
            if (exp_q.size() != 0 || req_valid != '0) idle_cnt++;
            else idle_cnt = 0;
            if (idle_cnt > 2 * TIMEOUT + 20) begin
                check("progress_watchdog", 64'(idle_cnt), 64'd0);
                idle_cnt = 0;
                exp_q.delete();
            end
        end
        prev_ld = gcd_ld;
    end

    // ---------------- driver ----------------
    logic [W-1:0] u_a [NREQ];
    logic [W-1:0] v_a [NREQ];
    bit           hold_all = 1'b0;
    bit           rand_mode = 1'b0;

    task automatic pack_bus();
        for (int i = 0; i < NREQ; i++) begin
            req_u[i*W +: W] = u_a[i];
            req_v[i*W +: W] = v_a[i];
        end
    endtask

    task automatic raise(input int i, input logic [W-1:0] u, input logic [W-1:0] v);
        u_a[i] = u;
        v_a[i] = v;
        req_valid[i] = 1'b1;
        pack_bus();
    endtask

    function automatic logic [W-1:0] rand_op();
        if ($urandom_range(0, 7) == 0) return '0;
        return W'($urandom_range(1, (1 << W) - 1));
    endfunction

    task automatic tick();
        exp_t ent;
        bit   nz;
        @(negedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                nz       = (u_a[i] != '0) && (v_a[i] != '0);
                ent.idx  = i;
                ent.u    = u_a[i];
                ent.v    = v_a[i];
                ent.err  = eng_dead && nz;
                ent.res  = ent.err ? '0 : ref_gcd(u_a[i], v_a[i]);
                ent.zero = !nz;
                ent.acc  = cyc;
                exp_q.push_back(ent);
                if (!hold_all) req_valid[i] = 1'b0;
            end else if (rand_mode) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    raise(i, rand_op(), rand_op());
                else if (req_valid[i] && $urandom_range(0, 63) == 0)
                    req_valid[i] = 1'b0;
            end
        end
        pack_bus();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int start;
        for (int i = 0; i < NREQ; i++) begin
            u_a[i] = '0;
            v_a[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1 resetb = 1'b1;

        // all four pending from reset with (8,4): grants 0,1,2,3,0
        hold_all = 1'b1;
        for (int i = 0; i < NREQ; i++) raise(i, 8'd8, 8'd4);
        start = rsp_count;
        for (int n = 0; n < 300 && rsp_count < start + 5; n++) tick();
        hold_all  = 1'b0;
        req_valid = '0;
        drain(200);

        // basic job, then a job whose stale done must be blanked
        raise(0, 8'd12, 8'd18);
        drain(200);
        raise(0, 8'd15, 8'd25);
        drain(200);

        // zero-operand jobs resolved locally
        raise(2, 8'd0, 8'd9);
        drain(50);
        raise(2, 8'd0, 8'd0);
        drain(50);
        raise(1, 8'd9, 8'd0);
        drain(50);

        // done arriving on the very timeout cycle wins
        lat_force = TIMEOUT - 1;
        raise(1, 8'd6, 8'd4);
        drain(200);
        lat_force = 0;

        // dead engine -> timeout error, then normal service resumes
        eng_dead = 1'b1;
        raise(3, 8'd10, 8'd15);
        drain(200);
        eng_dead = 1'b0;
        raise(3, 8'd10, 8'd15);
        drain(200);

        // reset in the middle of WAIT
        lat_force = 6;
        raise(0, 8'd7, 8'd21);
        for (int n = 0; n < 20 && !gcd_ld; n++) tick();
        tick();
        tick();
        @(posedge clk);
        #1 resetb = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #2 resetb = 1'b1;
        lat_force = 0;
        for (int i = 0; i < NREQ; i++) raise(i, W'($urandom_range(1, 255)), W'($urandom_range(1, 255)));
        drain(500);

        // randomized traffic
        rand_mode = 1'b1;
        repeat (1500) tick();
        rand_mode = 1'b0;
        drain(1000);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
